serial_subtractor_nbits: RTL

Bit-serial two's-complement subtractor for the calculator datapath: computes `a_i - b_i` one bit per clock, LSB first, using a single full-subtractor cell and a borrow register. It complements the combinational n-bit adder by providing the subtract path at minimal area. The block takes operands through a start/busy/done handshake and holds its result with flags until the next operation completes.

---
 rtl/serial_subtractor_nbits.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor_nbits.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow
// register produce a - b LSB first, with a start/busy/done handshake.
module serial_subtractor_nbits #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width-1:0] d_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int CntW = $clog2(width + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(width - 1);

  typedef enum logic [1:0] {
    Idle,
    Shift,
    Done
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] aShift_q, aShift_d;
  logic [width-1:0] bShift_q, bShift_d;
  logic [width-1:0] result_q, result_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             borrow_q, borrow_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [width-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             diffBit;
  logic             borrowNext;
  logic [width:0]   resultCat;

  // Full-subtractor cell on the current LSBs; resultCat[width:1] is the result
  // register with the new bit shifted in from the MSB side (works for width=1).
  assign diffBit    = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
  assign borrowNext = (~aShift_q[0] & bShift_q[0]) |
                      (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
  assign resultCat  = {diffBit, result_q};

  always_comb begin
    state_d  = state_q;
    aShift_d = aShift_q;
    bShift_d = bShift_q;
    result_d = result_q;
    count_d  = count_q;
    borrow_d = borrow_q;
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      Idle, Done: begin
        if (start_i) begin
          state_d  = Shift;
          aShift_d = a_i;
          bShift_d = b_i;
          aMsb_d   = a_i[width-1];
          bMsb_d   = b_i[width-1];
          result_d = '0;
          count_d  = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = Idle;
          busy_d  = 1'b0;
        end
      end

      Shift: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        result_d = resultCat[width:1];
        borrow_d = borrowNext;
        count_d  = count_q + CntW'(1);
        // Published flags include the final bit, which is only available here.
        if (count_q == LastCnt) begin
          state_d = Done;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = resultCat[width:1];
          bout_d  = borrowNext;
          ovf_d   = (aMsb_q ^ bMsb_q) & (diffBit ^ aMsb_q);
          zero_d  = (resultCat[width:1] == '0);
        end
      end

      default: begin
        state_d = Idle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      aShift_q <= '0;
      bShift_q <= '0;
      result_q <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aShift_q <= aShift_d;
      bShift_q <= bShift_d;
      result_q <= result_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = diff_q;
  assign bout_o = bout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule
